store_commit_buffer: RTL and testbench
======================================

// Module: store_commit_buffer
// PURPOSE
//  Sits directly downstream of the store unit; holds translated stores between address translation and the data cache.
//  Holds them in two FIFOs: a speculative queue filled by the store unit, and a commit queue filled on instruction commit.
//  Drains the commit queue into the dcache over a req/gnt handshake.
//  Flags page-offset aliasing against a probing load so the load unit can stall.
// PARAMETERS
//  XLEN          64  data width in bits; byte-enable width is XLEN/8
//  PLEN          56  physical address width
//  SPEC_DEPTH    4   speculative queue entries (power of 2, >=2)
//  COMMIT_DEPTH  4   commit queue entries (power of 2, >=2)
// PORTS
//  clk_i                  in   1           clock, rising edge
//  rst_i                  in   1           asynchronous reset, active-high
//  flush_i                in   1           pipeline flush; kills speculative entries
//  stall_st_pending_i     in   1           blocks dcache issue while high
//  valid_i                in   1           push one translated store
//  ready_o                out  1           speculative queue can take a push next cycle
//  paddr_i                in   PLEN        store physical address
//  data_i                 in   XLEN        store data, already lane-aligned
//  be_i                   in   XLEN/8      byte enables
//  data_size_i            in   2           0=B 1=H 2=W 3=D
//  commit_i               in   1           oldest speculative store is committed
//  commit_ready_o         out  1           commit queue has a free slot
//  page_offset_i          in   12          load page offset to check
//  page_offset_matches_o  out  1           some buffered or incoming store aliases the load
//  no_st_pending_o        out  1           commit queue empty
//  store_buffer_empty_o   out  1           both queues empty
//  req_o                  out  1           dcache write request
//  paddr_o                out  PLEN        request address (head of commit queue)
//  wdata_o / be_o / size_o  out  XLEN / XLEN/8 / 2   request payload
//  gnt_i                  in   1           dcache accepts request this cycle
// BEHAVIOUR
//  Reset (async, rst_i=1):
//   - Both queues' pointers and counts go to 0.
//   - ready_o=1, commit_ready_o=1, req_o=0, no_st_pending_o=1, store_buffer_empty_o=1, page_offset_matches_o=0.
//   - Payload outputs go to 0.
//  Speculative queue push:
//   - On valid_i && !flush_i, write {paddr,data,be,size} at the tail; the entry is visible next cycle.
//   - ready_o = spec_count <= SPEC_DEPTH-2. The one-slot margin covers a store already in flight.
//   - A push while spec_count==SPEC_DEPTH is a protocol error (assert); the entry is dropped and count is unchanged.
//  Commit:
//   - On commit_i, move the speculative head into the commit tail (spec pop, commit push) in the same cycle.
//   - commit_i with spec empty or commit_ready_o=0 is an error (assert); it is ignored.
//   - commit_ready_o = commit_count < COMMIT_DEPTH, computed from registered state. A same-cycle dcache pop does not free a slot early.
//  Flush:
//   - flush_i clears the speculative queue next cycle: count 0, head=tail.
//   - It overrides a same-cycle push. A same-cycle commit_i still completes, because committed stores survive flush.
//   - The commit queue is never flushed; only rst_i clears it.
//  Drain:
//   - req_o = commit_count!=0 && !stall_st_pending_i.
//   - The payload is the commit head, combinational from the registers, and stays stable while req_o && !gnt_i.
//   - On req_o && gnt_i, pop the head. The next entry is presented the following cycle, so the peak rate is one store per cycle.
//   - stall_st_pending_i rising while req_o is high and gnt_i is low: req_o drops. The dcache must not grant in that cycle.
//  Simultaneous events:
//   - Spec push + commit: spec count is unchanged.
//   - Commit push + dcache pop: commit count is unchanged.
//   - All four at once is legal; each pointer advances independently and wraps modulo its depth.
//  Status outputs:
//   - no_st_pending_o = commit_count==0.
//   - store_buffer_empty_o = spec_count==0 && commit_count==0.
//   - page_offset_matches_o is the combinational OR of three terms:
//     - a valid spec entry with paddr[11:3]==page_offset_i[11:3];
//     - a valid commit entry with the same match;
//     - valid_i && paddr_i[11:3]==page_offset_i[11:3].
// TESTING
//  1. Reset, then 3 pushes (paddr 0x80001008/10/18) -> ready_o drops after the 3rd push (SPEC_DEPTH=4); store_buffer_empty_o=0.
//  2. Commit 2, gnt_i=1 continuously -> req_o is high 2 cycles, paddr_o=0x80001008 then 0x80001010; no_st_pending_o=1 after.
//  3. 3 spec entries, flush_i coinciding with commit_i -> 1 entry in the commit queue, spec empty, the flushed 0x..18 never requested.
//  4. Fill the commit queue (4), gnt_i=0 -> commit_ready_o=0. Pulse gnt_i together with commit_i -> commit ignored, count drops to 3.
//  5. Commit entry paddr 0x80001238, page_offset_i=0x23C -> page_offset_matches_o=1. page_offset_i=0x240 -> 0.
//  6. req_o high with stall_st_pending_i=1 -> req_o=0. Release stall -> request resumes with the same payload. Assert rst_i mid-drain -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/store_commit_buffer.sv
// Two-stage store buffer: a speculative FIFO fed by the store unit and a commit FIFO
// drained into the dcache, plus page-offset alias detection for probing loads.
module store_commit_buffer #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned PLEN           = 56,
  parameter int unsigned SPEC_DEPTH     = 4,
  parameter int unsigned COMMIT_DEPTH   = 4,
  parameter bit          CHECK_PROTOCOL = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_st_pending_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PLEN-1:0]   paddr_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [1:0]        data_size_i,
  input  logic              commit_i,
  output logic              commit_ready_o,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_matches_o,
  output logic              no_st_pending_o,
  output logic              store_buffer_empty_o,
  output logic              req_o,
  output logic [PLEN-1:0]   paddr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [1:0]        size_o,
  input  logic              gnt_i
);

  localparam int unsigned BEW = XLEN / 8;
  localparam int unsigned SPW = $clog2(SPEC_DEPTH);
  localparam int unsigned CPW = $clog2(COMMIT_DEPTH);
  localparam int unsigned SCW = SPW + 1;
  localparam int unsigned CCW = CPW + 1;

  typedef struct packed {
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [BEW-1:0]  be;
    logic [1:0]      size;
  } entry_t;

  entry_t         r_spec_mem   [SPEC_DEPTH];
  entry_t         r_commit_mem [COMMIT_DEPTH];
  logic [SPW-1:0] r_spec_head;
  logic [SPW-1:0] r_spec_tail;
  logic [SCW-1:0] r_spec_count;
  logic [CPW-1:0] r_commit_head;
  logic [CPW-1:0] r_commit_tail;
  logic [CCW-1:0] r_commit_count;

  logic   w_spec_nonempty;
  logic   w_commit_nonempty;
  logic   w_commit_ready;
  logic   w_spec_push;
  logic   w_commit;
  logic   w_req;
  logic   w_pop;
  logic   w_spec_match;
  logic   w_commit_match;
  logic   w_in_match;
  entry_t w_in_entry;
  entry_t w_head_entry;

  assign w_in_entry        = {paddr_i, data_i, be_i, data_size_i};
  assign w_spec_nonempty   = (r_spec_count != '0);
  assign w_commit_nonempty = (r_commit_count != '0);
  assign w_commit_ready    = (r_commit_count < CCW'(COMMIT_DEPTH));
  assign w_spec_push       = valid_i && !flush_i && (r_spec_count != SCW'(SPEC_DEPTH));
  // Commit is gated on registered occupancy only; a same-cycle pop never frees a slot early.
  assign w_commit          = commit_i && w_spec_nonempty && w_commit_ready;
  assign w_req             = w_commit_nonempty && !stall_st_pending_i;
  assign w_pop             = w_req && gnt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_spec_head    <= '0;
      r_spec_tail    <= '0;
      r_spec_count   <= '0;
      r_commit_head  <= '0;
      r_commit_tail  <= '0;
      r_commit_count <= '0;
    end else begin
      if (flush_i) begin
        r_spec_head  <= r_spec_tail;
        r_spec_count <= '0;
      end else begin
        if (w_spec_push) r_spec_tail <= r_spec_tail + SPW'(1);
        if (w_commit)    r_spec_head <= r_spec_head + SPW'(1);
        r_spec_count <= r_spec_count + SCW'(w_spec_push) - SCW'(w_commit);
      end
      if (w_commit) r_commit_tail <= r_commit_tail + CPW'(1);
      if (w_pop)    r_commit_head <= r_commit_head + CPW'(1);
      r_commit_count <= r_commit_count + CCW'(w_commit) - CCW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_spec_push) r_spec_mem[r_spec_tail]     <= w_in_entry;
    if (w_commit)    r_commit_mem[r_commit_tail] <= r_spec_mem[r_spec_head];
  end

  // Only entries between head and head+count are live; stale slots must not alias.
  always_comb begin
    w_spec_match = 1'b0;
    for (int k = 0; k < SPEC_DEPTH; k++) begin
      if ((SCW'(k) < r_spec_count) &&
          (r_spec_mem[r_spec_head + SPW'(k)].paddr[11:3] == page_offset_i[11:3]))
        w_spec_match = 1'b1;
    end
  end

  always_comb begin
    w_commit_match = 1'b0;
    for (int k = 0; k < COMMIT_DEPTH; k++) begin
      if ((CCW'(k) < r_commit_count) &&
          (r_commit_mem[r_commit_head + CPW'(k)].paddr[11:3] == page_offset_i[11:3]))
        w_commit_match = 1'b1;
    end
  end

  assign w_in_match   = valid_i && (paddr_i[11:3] == page_offset_i[11:3]);
  assign w_head_entry = w_commit_nonempty ? r_commit_mem[r_commit_head] : '0;

  assign ready_o               = (r_spec_count <= SCW'(SPEC_DEPTH - 2));
  assign commit_ready_o        = w_commit_ready;
  assign no_st_pending_o       = !w_commit_nonempty;
  assign store_buffer_empty_o  = !w_spec_nonempty && !w_commit_nonempty;
  assign page_offset_matches_o = w_spec_match || w_commit_match || w_in_match;
  assign req_o                 = w_req;
  assign paddr_o               = w_head_entry.paddr;
  assign wdata_o               = w_head_entry.data;
  assign be_o                  = w_head_entry.be;
  assign size_o                = w_head_entry.size;

  generate
    if (CHECK_PROTOCOL) begin : g_protocol_check
      always @(posedge clk_i) begin
        if (!rst_i) begin
          assert (!(valid_i && !flush_i && (r_spec_count == SCW'(SPEC_DEPTH))))
            else $error("store pushed into a full speculative queue");
          assert (!(commit_i && (!w_spec_nonempty || !w_commit_ready)))
            else $error("commit with empty speculative queue or full commit queue");
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomized and directed bench for store_commit_buffer against a queue-based model.
module tb_store_commit_buffer;

  localparam int PLEN = 56;
  localparam int XLEN = 64;
  localparam int BEW  = 8;
  localparam int SD   = 4;
  localparam int CD   = 4;

  typedef struct packed {
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [BEW-1:0]  be;
    logic [1:0]      size;
  } ent_t;

  typedef logic [6+PLEN+XLEN+BEW+2-1:0] obs_t;
  localparam obs_t RESET_OBS = {6'b110110, 130'd0};

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            stall_st_pending_i;
  logic            valid_i;
  logic            ready_o;
  logic [PLEN-1:0] paddr_i;
  logic [XLEN-1:0] data_i;
  logic [BEW-1:0]  be_i;
  logic [1:0]      data_size_i;
  logic            commit_i;
  logic            commit_ready_o;
  logic [11:0]     page_offset_i;
  logic            page_offset_matches_o;
  logic            no_st_pending_o;
  logic            store_buffer_empty_o;
  logic            req_o;
  logic [PLEN-1:0] paddr_o;
  logic [XLEN-1:0] wdata_o;
  logic [BEW-1:0]  be_o;
  logic [1:0]      size_o;
  logic            gnt_i;
  obs_t            obs;

  ent_t spec_q[$];
  ent_t commit_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  store_commit_buffer #(
    .XLEN(XLEN), .PLEN(PLEN), .SPEC_DEPTH(SD), .COMMIT_DEPTH(CD), .CHECK_PROTOCOL(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_st_pending_i(stall_st_pending_i),
    .valid_i(valid_i), .ready_o(ready_o), .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i),
    .data_size_i(data_size_i), .commit_i(commit_i), .commit_ready_o(commit_ready_o),
    .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
    .no_st_pending_o(no_st_pending_o), .store_buffer_empty_o(store_buffer_empty_o),
    .req_o(req_o), .paddr_o(paddr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
    .gnt_i(gnt_i)
  );

  assign obs = {ready_o, commit_ready_o, req_o, no_st_pending_o, store_buffer_empty_o,
                page_offset_matches_o, paddr_o, wdata_o, be_o, size_o};

  function automatic obs_t model_eval();
    logic ready, cready, req, nsp, empty, match;
    ent_t head;
    ready  = (spec_q.size() <= SD - 2);
    cready = (commit_q.size() < CD);
    req    = (commit_q.size() != 0) && !stall_st_pending_i;
    nsp    = (commit_q.size() == 0);
    empty  = (spec_q.size() == 0) && (commit_q.size() == 0);
    match  = valid_i && (paddr_i[11:3] == page_offset_i[11:3]);
    foreach (spec_q[i])   if (spec_q[i].paddr[11:3] == page_offset_i[11:3]) match = 1'b1;
    foreach (commit_q[i]) if (commit_q[i].paddr[11:3] == page_offset_i[11:3]) match = 1'b1;
    head = (commit_q.size() != 0) ? commit_q[0] : '0;
    return {ready, cready, req, nsp, empty, match, head};
  endfunction

  task automatic model_clock();
    bit   do_push, do_commit, do_pop;
    ent_t e;
    if (rst_i) begin
      spec_q.delete();
      commit_q.delete();
      return;
    end
    do_pop    = (commit_q.size() != 0) && !stall_st_pending_i && gnt_i;
    do_commit = commit_i && (spec_q.size() != 0) && (commit_q.size() < CD);
    do_push   = valid_i && !flush_i && (spec_q.size() < SD);
    if (do_pop) void'(commit_q.pop_front());
    if (do_commit) commit_q.push_back(spec_q.pop_front());
    if (flush_i) spec_q.delete();
    else if (do_push) begin
      e = {paddr_i, data_i, be_i, data_size_i};
      spec_q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_clock();
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; stall_st_pending_i = 0; valid_i = 0; paddr_i = '0; data_i = '0;
    be_i = '0; data_size_i = '0; commit_i = 0; page_offset_i = '0; gnt_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    cycle();
    rst_i = 0;
    #1;
  endtask

  task automatic push_one(input logic [PLEN-1:0] p, output logic [XLEN-1:0] d);
    d = {$urandom, $urandom};
    valid_i = 1; paddr_i = p; data_i = d; be_i = 8'($urandom); data_size_i = 2'($urandom);
    #1;
    cycle();
    valid_i = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    cycle();
    n_vec++;
    if (obs !== RESET_OBS) begin
      n_err++; $display("FAIL reset_in: got %h want %h", obs, RESET_OBS);
    end
    rst_i = 0;
    cycle();
    n_vec++;
    if (obs !== RESET_OBS) begin
      n_err++; $display("FAIL reset_out: got %h want %h", obs, RESET_OBS);
    end
  endtask

  task automatic test_push();
    logic [XLEN-1:0] d;
    for (int k = 0; k < 3; k++) begin
      push_one(56'h80001008 + PLEN'(8 * k), d);
      n_vec++;
      if (ready_o !== (k < 2)) begin
        n_err++; $display("FAIL push_ready_%0d: got %b want %b", k, ready_o, (k < 2));
      end
    end
    n_vec++;
    if (store_buffer_empty_o !== 1'b0) begin
      n_err++; $display("FAIL push_empty: got %b want 0", store_buffer_empty_o);
    end
  endtask

  task automatic test_drain();
    logic [PLEN-1:0] got[$];
    gnt_i = 1;
    for (int c = 0; c < 6; c++) begin
      commit_i = (c < 2);
      #1;
      if (req_o) got.push_back(paddr_o);
      cycle();
    end
    commit_i = 0; gnt_i = 0;
    #1;
    n_vec++;
    if (got.size() != 2 || got[0] !== 56'h80001008 || got[1] !== 56'h80001010) begin
      n_err++;
      $display("FAIL drain_seq: got %0d reqs (%h %h) want 2 (80001008 80001010)",
               got.size(), (got.size() > 0) ? got[0] : '0, (got.size() > 1) ? got[1] : '0);
    end
    n_vec++;
    if (no_st_pending_o !== 1'b1) begin
      n_err++; $display("FAIL drain_nsp: got %b want 1", no_st_pending_o);
    end
  endtask

  task automatic test_flush_commit();
    logic [XLEN-1:0] d;
    logic [PLEN-1:0] got[$];
    do_reset();
    for (int k = 0; k < 3; k++) push_one(56'h80001008 + PLEN'(8 * k), d);
    flush_i = 1; commit_i = 1;
    #1;
    cycle();
    flush_i = 0; commit_i = 0;
    #1;
    n_vec++;
    if ({no_st_pending_o, ready_o} !== 2'b01) begin
      n_err++; $display("FAIL flush_state: got nsp/ready %b want 01", {no_st_pending_o, ready_o});
    end
    gnt_i = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_o) got.push_back(paddr_o);
      cycle();
    end
    gnt_i = 0;
    #1;
    n_vec++;
    if (got.size() != 1 || got[0] !== 56'h80001008) begin
      n_err++; $display("FAIL flush_reqs: got %0d reqs first %h want 1 req 80001008",
                        got.size(), (got.size() > 0) ? got[0] : '0);
    end
    n_vec++;
    if (store_buffer_empty_o !== 1'b1) begin
      n_err++; $display("FAIL flush_empty: got %b want 1", store_buffer_empty_o);
    end
  endtask

  task automatic test_commit_full();
    logic [XLEN-1:0] d;
    int nreq;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_one(56'h80002000 + PLEN'(8 * k), d);
      commit_i = 1;
      #1;
      cycle();
      commit_i = 0;
    end
    push_one(56'h80002100, d);
    n_vec++;
    if ({commit_ready_o, req_o, paddr_o} !== {2'b01, 56'h80002000}) begin
      n_err++; $display("FAIL full_state: got cr=%b req=%b pa=%h want cr=0 req=1 pa=80002000",
                        commit_ready_o, req_o, paddr_o);
    end
    commit_i = 1; gnt_i = 1;
    #1;
    cycle();
    commit_i = 0; gnt_i = 0;
    #1;
    n_vec++;
    if ({commit_ready_o, paddr_o} !== {1'b1, 56'h80002008}) begin
      n_err++; $display("FAIL full_pop: got cr=%b pa=%h want cr=1 pa=80002008", commit_ready_o, paddr_o);
    end
    gnt_i = 1; nreq = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_o) nreq++;
      cycle();
    end
    gnt_i = 0;
    #1;
    n_vec++;
    if (nreq != 3) begin
      n_err++; $display("FAIL full_count: got %0d reqs want 3", nreq);
    end
    n_vec++;
    if ({store_buffer_empty_o, no_st_pending_o} !== 2'b01) begin
      n_err++; $display("FAIL full_specleft: got empty/nsp %b want 01",
                        {store_buffer_empty_o, no_st_pending_o});
    end
  endtask

  task automatic test_alias();
    logic [XLEN-1:0] d;
    do_reset();
    stall_st_pending_i = 1;
    push_one(56'h80001238, d);
    commit_i = 1;
    #1;
    cycle();
    commit_i = 0;
    page_offset_i = 12'h23C;
    #1;
    n_vec++;
    if (page_offset_matches_o !== 1'b1) begin
      n_err++; $display("FAIL alias_commit_hit: got %b want 1", page_offset_matches_o);
    end
    page_offset_i = 12'h240;
    #1;
    n_vec++;
    if (page_offset_matches_o !== 1'b0) begin
      n_err++; $display("FAIL alias_commit_miss: got %b want 0", page_offset_matches_o);
    end
    valid_i = 1; paddr_i = 56'h80004240;
    #1;
    n_vec++;
    if (page_offset_matches_o !== 1'b1) begin
      n_err++; $display("FAIL alias_incoming: got %b want 1", page_offset_matches_o);
    end
    valid_i = 0;
    push_one(56'h80001510, d);
    page_offset_i = 12'h517;
    #1;
    n_vec++;
    if (page_offset_matches_o !== 1'b1) begin
      n_err++; $display("FAIL alias_spec_hit: got %b want 1", page_offset_matches_o);
    end
    page_offset_i = 12'h518;
    #1;
    n_vec++;
    if (page_offset_matches_o !== 1'b0) begin
      n_err++; $display("FAIL alias_spec_miss: got %b want 0", page_offset_matches_o);
    end
    stall_st_pending_i = 0;
  endtask

  task automatic test_stall_reset();
    logic [XLEN-1:0] da, db;
    do_reset();
    push_one(56'h80003008, da);
    push_one(56'h80003010, db);
    commit_i = 1;
    #1;
    cycle();
    cycle();
    commit_i = 0;
    stall_st_pending_i = 1;
    #1;
    n_vec++;
    if (req_o !== 1'b0) begin
      n_err++; $display("FAIL stall_req: got %b want 0", req_o);
    end
    cycle();
    cycle();
    stall_st_pending_i = 0;
    #1;
    n_vec++;
    if ({req_o, paddr_o, wdata_o} !== {1'b1, 56'h80003008, da}) begin
      n_err++; $display("FAIL stall_resume: got req=%b pa=%h d=%h want 1 80003008 %h",
                        req_o, paddr_o, wdata_o, da);
    end
    gnt_i = 1;
    #1;
    cycle();
    gnt_i = 0;
    #1;
    n_vec++;
    if ({req_o, paddr_o, wdata_o} !== {1'b1, 56'h80003010, db}) begin
      n_err++; $display("FAIL stall_next: got req=%b pa=%h d=%h want 1 80003010 %h",
                        req_o, paddr_o, wdata_o, db);
    end
    rst_i = 1;
    #1;
    n_vec++;
    if (obs !== RESET_OBS) begin
      n_err++; $display("FAIL async_reset: got %h want %h", obs, RESET_OBS);
    end
    cycle();
    rst_i = 0;
    #1;
  endtask

  task automatic test_random();
    obs_t exp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      valid_i            = ($urandom_range(0, 9) < 6);
      paddr_i            = PLEN'({$urandom, $urandom});
      paddr_i[11:3]      = 9'($urandom_range(0, 15));
      data_i             = {$urandom, $urandom};
      be_i               = 8'($urandom);
      data_size_i        = 2'($urandom);
      commit_i           = 1'($urandom_range(0, 1));
      flush_i            = ($urandom_range(0, 19) == 0);
      stall_st_pending_i = ($urandom_range(0, 4) == 0);
      gnt_i              = 1'($urandom_range(0, 1));
      page_offset_i      = {9'($urandom_range(0, 15)), 3'($urandom)};
      #1;
      exp = model_eval();
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL random_c%0d: got %h want %h", c, obs, exp);
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_i = 1;
    test_reset();
    test_push();
    test_drain();
    test_flush_commit();
    test_commit_full();
    test_alias();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
